// File: rtl/storm_trace_buf.sv
// rtl/storm_trace_buf.sv - STORM retire-trace FIFO with halt detection and FWFT drain port
module storm_trace_buf #(
    parameter int          DEPTH_LOG2 = 4,
    parameter int          ADDR_W     = 9,
    parameter logic [15:0] HALT_IR    = 16'hCFFF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    iArm,
    input  logic                    iClear,
    input  logic                    iRetire,
    input  logic [ADDR_W-1:0]       iPC,
    input  logic [15:0]             iIR,
    input  logic [3:0]              iFlags,
    input  logic                    iRdAck,
    output logic                    oRdValid,
    output logic [21+ADDR_W-1:0]    oRdData,
    output logic [DEPTH_LOG2:0]     oLevel,
    output logic [1:0]              oState,
    output logic                    oHalt,
    output logic                    oOverflow,
    output logic [7:0]              oDropCnt
);

    localparam int ENTRY_W = 21 + ADDR_W;
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int LVL_W   = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [ADDR_W-1:0]       last_pc;
    logic                    last_pc_valid;
    logic                    overflow_q;
    logic [7:0]              drop_cnt;

    logic capture, pop, push_ok, drop, full, empty, repeat_bit, arm_start;

    assign empty      = (level_q == '0);
    assign full       = (level_q == LVL_FULL);
    assign capture    = (state_q == ARMED) && iRetire && !iClear;
    // An ack on an empty FIFO is ignored, even when a push lands that cycle
    assign pop        = iRdAck && !empty && !iClear;
    assign push_ok    = capture && (!full || pop);
    assign drop       = capture && full && !pop;
    assign repeat_bit = last_pc_valid && (iPC == last_pc);
    assign arm_start  = (state_q == IDLE) && iArm && !iClear;

    always_comb begin
        state_d = state_q;
        if (iClear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (iArm) state_d = ARMED;
                ARMED:   if (iRetire && (iIR == HALT_IR)) state_d = HALTED;
                HALTED:  state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_q       <= '0;
            last_pc       <= '0;
            last_pc_valid <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            state_q <= state_d;
            if (iClear) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                level_q       <= '0;
                last_pc       <= '0;
                last_pc_valid <= 1'b0;
                overflow_q    <= 1'b0;
                drop_cnt      <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
                level_q <= level_d;
                if (drop) begin
                    overflow_q <= 1'b1;
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end
                // Dropped retires still advance the repeat tracker
                if (capture) begin
                    last_pc       <= iPC;
                    last_pc_valid <= 1'b1;
                end else if (arm_start) begin
                    last_pc_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) mem[wr_ptr] <= {repeat_bit, iFlags, iPC, iIR};
    end

    assign oRdValid  = !empty;
    assign oRdData   = empty ? '0 : mem[rd_ptr];
    assign oLevel    = level_q;
    assign oState    = state_q;
    assign oHalt     = (state_q == HALTED);
    assign oOverflow = overflow_q;
    assign oDropCnt  = drop_cnt;

endmodule

// File: doc/storm_trace_buf.md
# storm_trace_buf

Hardware retire-trace buffer for the STORM core. It watches the WB stage's retired-instruction stream and records PC, instruction word, flags and a repeat marker into an on-chip FIFO. It detects the halt instruction 16'hCFFF and freezes capture there. A host or debug port drains the FIFO through a first-word-fall-through read handshake. This gives the same execution log as the simulation bench, but on silicon.

## Interface
- DEPTH_LOG2, default 4: FIFO depth = 2^DEPTH_LOG2 entries.
- ADDR_W, default 9: instruction address width (512-word IRAM).
- HALT_IR, default 16'hCFFF: instruction word that terminates capture.
- Clk  in  1: single clock, rising edge.
- Reset  in  1: asynchronous, active-low. 0 = reset.
- iArm  in  1: one-cycle pulse; IDLE -> ARMED.
- iClear  in  1: one-cycle pulse; flush FIFO and counters, go to IDLE.
- iRetire  in  1: one instruction retires this cycle.
- iPC  in  ADDR_W: PC of the retiring instruction.
- iIR  in  16: instruction word of the retiring instruction.
- iFlags  in  4: {O,S,Z,C} after the retiring instruction.
- iRdAck  in  1: pop the head entry. Ignored when oRdValid=0.
- oRdValid  out  1: FIFO not empty.
- oRdData  out  21+ADDR_W: head entry {Repeat, Flags[3:0], PC, IR}, MSB first.
- oLevel  out  DEPTH_LOG2+1: current entry count.
- oState  out  2: 0=IDLE, 1=ARMED, 2=HALTED.
- oHalt  out  1: high while oState==HALTED.
- oOverflow  out  1: sticky; at least one entry was dropped.
- oDropCnt  out  8: dropped-entry count, saturating at 255.

## Operation
- State machine:
  - IDLE: nothing is captured. iArm moves to ARMED.
  - ARMED: every iRetire pushes one entry.
    - If the retired iIR == HALT_IR, the entry is pushed (or dropped, per the full-FIFO rule), then the state moves to HALTED.
  - HALTED: nothing is captured. iArm is ignored. Only iClear or Reset leave this state, both to IDLE.
- iClear has priority over iArm and over any push in the same cycle.
  - It empties the FIFO, zeroes oDropCnt and oOverflow, and clears the last-PC register and its valid bit.
  - It does not touch FIFO RAM contents. Only pointers are reset.
- Repeat bit is 1 when iPC equals the PC of the previous captured retire since arming. This is a self-loop or stalled-PC marker.
  - The first retire after IDLE->ARMED always has Repeat=0.
  - The last-PC register updates on every captured retire, including dropped ones.
- Full FIFO with a push:
  - If iRdAck is also high, pop and push both happen and nothing is dropped.
  - Otherwise the new entry is discarded, oOverflow is set, and oDropCnt increments, saturating at 255.
- Empty FIFO with a push and iRdAck in the same cycle: the push succeeds and the ack is ignored.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. The full/empty distinction comes from oLevel.
- Storage is a register array or inferred RAM, written synchronously. The read is combinational from the head pointer.

## Timing
- Reset (asynchronous assertion, synchronous-safe deassertion) sets:
  - oState=IDLE, oHalt=0, oRdValid=0, oLevel=0, oOverflow=0, oDropCnt=0, oRdData=0, last-PC valid=0.
  - oRdData reads as 0 while empty, by gating.
- iArm at edge N: ARMED from N. A retire sampled at edge N+1 is the first capturable one.
- Push latency is 1 cycle. A retire sampled at edge N gives oRdValid=1 and oRdData for that entry after edge N (if the FIFO was empty).
- Pop: iRdAck sampled at edge N advances the head. The next entry, or oRdValid=0, appears after edge N.
- oHalt rises after the edge that samples the halt retire, in the same cycle its entry becomes visible.
- oLevel, oOverflow and oDropCnt are all registered and update on the same edge as the push or pop.
- Reset asserted mid-operation drops all state immediately. There is no partial-entry recovery.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Arm, then retire PC=000,001,002 with IR=1234,5678,9ABC and flags 0,4,2, then drain. Expect oRdData={0,0,000,1234}, {0,4,001,5678}, {0,2,002,9ABC} in order, then oRdValid=0 and oLevel=0.
- Arm, retire PC=010 three times (IR=C00F). Expect Repeat bits 0,1,1. Then iClear, iArm, retire PC=010. Expect Repeat=0.
- Depth 16: arm, 20 retires with no reads. Expect oLevel=16, oOverflow=1, oDropCnt=4, and entries 0-15 drained intact. Then retire while full with iRdAck=1. Expect oDropCnt to stay 4 and the new entry to land at the tail.
- Arm, retire IR=0001, then IR=CFFF, then IR=0002. Expect oHalt=1 after the CFFF edge and oLevel=2. Further iArm pulses are ignored. iClear gives oState=0 and oLevel=0.
- Retire with no iArm, and retire in HALTED. Expect oLevel to stay 0. Simultaneous iArm+iClear gives IDLE.
- Pull Reset low asynchronously mid-burst with oLevel=7. Expect all outputs at reset values before the next edge.
- Force 300 drops. Expect oDropCnt=255.
